// File: rtl/chunked_add_seq_if.sv
// Operand/result handshake bundle for chunked_add_seq: valid/ready on the
// operand side and on the result side, sharing one N-bit data width.
interface chunked_add_seq_if #(
  parameter int N = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ci;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         co;

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, s, co
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, s, co
  );
endinterface

// File: rtl/chunked_add_seq.sv
// Sequential wide adder: {co,s} = a + b + ci, evaluated W bits per clock with
// the carry registered between chunks; valid/ready handshake on both sides.
module chunked_add_seq #(
  parameter int N = 64,
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst,
  chunked_add_seq_if.slave  bus
);

  localparam int WS = (W < 1) ? 1 : W;
  localparam int NC = N / WS;
  localparam int CW = $clog2(NC + 1);

  if ((W < 1) || ((N % WS) != 0)) begin : g_bad_config
    $error("chunked_add_seq: W must be >= 1 and divide N evenly");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] idx;
  logic          carry;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  s_q;
  logic          co_q;
  logic [WS-1:0] a_chunk;
  logic [WS-1:0] b_chunk;
  logic [WS:0]   chunk_sum;
  logic          accept;
  logic          last;

  assign bus.in_ready  = (state == IDLE) & ~rst;
  assign bus.out_valid = (state == DONE);
  assign bus.s         = s_q;
  assign bus.co        = co_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign last   = (idx == CW'(NC - 1));

  // Constant-index mux keeps the chunk selection free of variable part-selects.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < NC; k++) begin
      if (idx == CW'(k)) begin
        a_chunk = a_q[k*WS +: WS];
        b_chunk = b_q[k*WS +: WS];
      end
    end
  end

  assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{WS{1'b0}}, carry};

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = RUN;
      RUN:     if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Operands stay frozen through RUN; only s, carry and idx advance per chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      co_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            carry <= bus.ci;
            idx   <= '0;
            s_q   <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < NC; k++) begin
            if (idx == CW'(k)) s_q[k*WS +: WS] <= chunk_sum[WS-1:0];
          end
          carry <= chunk_sum[WS];
          idx   <= idx + 1'b1;
          if (last) co_q <= chunk_sum[WS];
        end
        default: ;
      endcase
    end
  end

endmodule
